// File: rtl/store_commit_buffer.sv
// Committed-store buffer: accepts retired stores and drains them to memory in order.
// Define STORE_FWD_EN to compile in store-to-load forwarding of full-word entries.
`timescale 1ns/1ps
module store_commit_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     store_valid_in,
  input  logic [31:0]              store_addr_in,
  input  logic [31:0]              store_value_in,
  input  logic [1:0]               store_size_in,
  output logic                     store_read_out,
  output logic                     mem_req_out,
  output logic [31:0]              mem_addr_out,
  output logic [31:0]              mem_wdata_out,
  output logic [3:0]               mem_be_out,
  input  logic                     mem_ack_in,
  input  logic [31:0]              load_addr_in,
  output logic                     load_conflict_out,
  output logic                     load_fwd_valid_out,
  output logic [31:0]              load_fwd_data_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     empty_out,
  output logic                     misalign_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  logic [29:0]   waddr_q [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic          push, pop, busy, misalign, hit;
  logic [31:0]   lane_data, hit_data;
  logic [3:0]    lane_be, hit_be;

  // Lane placement of the incoming store within its 32-bit word.
  always_comb begin
    lane_data = store_value_in;
    lane_be   = 4'b1111;
    misalign  = 1'b0;
    case (store_size_in)
      2'd0: begin
        lane_be   = 4'b0001 << store_addr_in[1:0];
        lane_data = {24'h0, store_value_in[7:0]} << {store_addr_in[1:0], 3'b000};
      end
      2'd1: begin
        lane_be   = store_addr_in[1] ? 4'b1100 : 4'b0011;
        lane_data = {16'h0, store_value_in[15:0]} << {store_addr_in[1], 4'b0000};
        misalign  = store_addr_in[0];
      end
      default: misalign = |store_addr_in[1:0];
    endcase
  end

  assign busy = rst_in && (state_q == StBusy);
  assign push = rst_in && store_valid_in && (count_q < CW'(DEPTH));
  assign pop  = busy && mem_ack_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      StIdle:  if (count_q != '0) state_d = StBusy;
      StBusy:  if (mem_ack_in && (count_q == CW'(1)) && !push) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      waddr_q[wr_ptr_q] <= store_addr_in[31:2];
      wdata_q[wr_ptr_q] <= lane_data;
      be_q[wr_ptr_q]    <= lane_be;
    end
  end

  assign store_read_out = push;
  assign misalign_out   = push && misalign;
  assign mem_req_out    = busy;
  assign mem_addr_out   = busy ? {waddr_q[rd_ptr_q], 2'b00} : '0;
  assign mem_wdata_out  = busy ? wdata_q[rd_ptr_q] : '0;
  assign mem_be_out     = busy ? be_q[rd_ptr_q] : '0;
  assign count_out      = rst_in ? count_q : '0;
  assign empty_out      = !rst_in || (count_q == '0);

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_be   = '0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (waddr_q[idx] == load_addr_in[31:2])) begin
        hit      = 1'b1;
        hit_be   = be_q[idx];
        hit_data = wdata_q[idx];
      end
    end
  end

`ifdef STORE_FWD_EN
  logic fwd;
  logic unused_load;
  assign fwd                = rst_in && hit && (hit_be == 4'b1111);
  assign load_fwd_valid_out = fwd;
  assign load_fwd_data_out  = fwd ? hit_data : '0;
  assign load_conflict_out  = rst_in && hit && !fwd;
  assign unused_load        = ^load_addr_in[1:0];
`else
  logic unused_load;
  assign load_fwd_valid_out = 1'b0;
  assign load_fwd_data_out  = '0;
  assign load_conflict_out  = rst_in && hit;
  assign unused_load        = ^{load_addr_in[1:0], hit_be, hit_data};
`endif

endmodule

// File: doc/store_commit_buffer.md
STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of committed-store entries (power of two, >=2).
REQ-002 SHALL have ports clk_in input 1 (system clock) and rst_in input 1 (reset); one clock; reset is synchronous and active-low.
REQ-003 SHALL have store_valid_in input 1, meaning the reorder-buffer head holds a ready store.
REQ-004 SHALL have store_addr_in input 32, meaning the byte address of that store.
REQ-005 SHALL have store_value_in input 32, meaning the store data, right-aligned.
REQ-006 SHALL have store_size_in input 2, encoded 0=byte, 1=half, 2=word (3 is treated as word).
REQ-007 SHALL have store_read_out output 1, a one-cycle accept pulse that retires the store at the reorder-buffer head.
REQ-008 SHALL have mem_req_out output 1, mem_addr_out output 32 (word-aligned), mem_wdata_out output 32 and mem_be_out output 4 (byte enables).
REQ-009 SHALL have mem_ack_in input 1, meaning the memory accepted the write on this cycle.
REQ-010 SHALL have load_addr_in input 32, meaning the address of the load being checked.
REQ-011 SHALL have load_conflict_out output 1, load_fwd_valid_out output 1 and load_fwd_data_out output 32.
REQ-012 SHALL have count_out output $clog2(DEPTH)+1, empty_out output 1 and misalign_out output 1.

Function
REQ-013 SHALL drive store_read_out = store_valid_in && (count < DEPTH), combinationally in the same cycle.
REQ-014 SHALL enqueue at the tail on each clock edge where store_read_out is high.
REQ-015 SHALL, on enqueue, store the word address (addr[31:2]), the lane-shifted data and the byte enables:
- byte: be = 1<<addr[1:0], data shifted left by 8*addr[1:0].
- half: be = 0011 or 1100 selected by addr[1], data shifted by 16*addr[1].
- word: be = 1111, no shift.
REQ-016 SHALL pulse misalign_out for one cycle on enqueue of a half with addr[0]=1 or a word with addr[1:0]!=0; the store is still written using the lane rules of REQ-015.
REQ-017 SHALL use a two-state drain FSM:
- IDLE -> BUSY when count > 0.
- BUSY -> IDLE when mem_ack_in is high and count == 1 with no simultaneous enqueue.
- Otherwise BUSY stays in BUSY.
REQ-018 SHALL, in BUSY, hold mem_req_out high with mem_addr_out, mem_wdata_out and mem_be_out equal to the head entry and stable until mem_ack_in is seen.
REQ-019 SHALL pop the head on the edge where mem_req_out && mem_ack_in; the next entry, if any, is presented in the following cycle with no idle gap.
REQ-020 SHALL, on a simultaneous enqueue and pop, keep count unchanged and advance both pointers.
REQ-021 SHALL, when count == DEPTH, hold store_read_out low even if mem_ack_in is high that cycle.
REQ-022 SHALL keep pointers modulo DEPTH with wrap-around; count_out SHALL equal the number of valid entries and empty_out SHALL equal (count == 0).
REQ-023 SHALL ignore mem_ack_in when mem_req_out is low.
REQ-024 SHALL set load_conflict_out combinationally whenever any valid entry's word address equals load_addr_in[31:2] and forwarding does not apply.
REQ-025 SHALL compare against entries in both states, including the entry currently being drained.

Reset
REQ-026 SHALL, with rst_in low at a clock edge, clear the pointers and count and return the FSM to IDLE.
REQ-027 SHALL hold these output values during and after reset: store_read_out 0, mem_req_out 0, mem_addr_out 0, mem_wdata_out 0, mem_be_out 0, misalign_out 0, load outputs 0, count_out 0, empty_out 1.
REQ-028 SHALL, on reset in BUSY, drop mem_req_out in the next cycle and discard pending entries.

Configuration
REQ-029 SHALL use the macro STORE_FWD_EN to compile store-to-load forwarding in or out.
REQ-030 SHALL, when STORE_FWD_EN is defined, drive load_fwd_valid_out = 1 and load_fwd_data_out = that entry's data if the youngest matching entry has be=1111; load_conflict_out is then 0.
REQ-031 SHALL, when STORE_FWD_EN is defined and the youngest matching entry has partial byte enables, drive load_conflict_out = 1 and load_fwd_valid_out = 0.
REQ-032 SHALL, when STORE_FWD_EN is undefined, tie load_fwd_valid_out and load_fwd_data_out to 0, with load_conflict_out = any match.

Verification
REQ-033 SHALL cover: sw addr 0x100, value 0xDEADBEEF; ack after 3 cycles -> read pulse, req held 3 cycles, addr 0x100, be 1111, data 0xDEADBEEF, empty_out returns to 1.
REQ-034 SHALL cover: sb addr 0x203, value 0xAB -> mem_addr_out 0x200, be 1000, data 0xAB000000, misalign_out 0.
REQ-035 SHALL cover: sh addr 0x101 -> misalign_out pulses, be 0011.
REQ-036 SHALL cover: 5 stores with ack held 0 and DEPTH=4 -> four accepts, fifth read held low; one ack -> fifth accepted the next cycle; all five drain in order through wrap-around.
REQ-037 SHALL cover: sw 0x40=0x11111111 then sw 0x40=0x22222222 pending, load 0x40 -> with STORE_FWD_EN fwd_valid 1, data 0x22222222; without it conflict 1.
REQ-038 SHALL cover: rst_in low while BUSY with 3 entries -> mem_req_out 0 in the next cycle, count_out 0, no further writes.
